// File: rtl/text_term_writer_if.sv
// rtl/text_term_writer_if.sv - byte stream input and display-memory write port of the text terminal writer
interface text_term_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/text_term_writer.sv
// rtl/text_term_writer.sv - character terminal front end writing {attr, char} words into text display memory
// Optional TEXT_TERM_ATTR_ESC_EN: ESC (0x1B) makes the next accepted byte the current attribute.
module text_term_writer #(
  parameter int              COLS       = 40,
  parameter int              ROWS       = 20,
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]      DEF_ATTR   = 8'h0F,
  parameter logic [7:0]      BLANK_CHAR = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  text_term_writer_if.slave        bus,
  output logic [$clog2(COLS)-1:0]  cursor_col_o,
  output logic [$clog2(ROWS)-1:0]  cursor_row_o,
  output logic                     busy_o
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int NCELL = ROWS * COLS;
  localparam int CNT_W = $clog2(NCELL + 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
`ifdef TEXT_TERM_ATTR_ESC_EN
  localparam logic [7:0] CH_ESC = 8'h1B;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CLR_SCREEN, S_CLR_LINE, S_ESC_ATTR} state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;
  logic [7:0]        attr;
  logic [CNT_W-1:0]  cnt;
  logic              ready_r;
  logic              busy_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic [7:0]        b;
  logic              accept;
  logic              is_print;
  logic              last_col;
  logic              last_row;
  logic              do_newline;
  logic [ROW_W-1:0]  row_nl;
  logic [ADDR_W-1:0] base_nl;
  logic [ADDR_W-1:0] cur_addr;

  function automatic logic [DATA_W-1:0] word(input logic [7:0] a, input logic [7:0] c);
    return DATA_W'({a, c});
  endfunction

  assign b          = bus.byte_data_i;
  assign accept     = bus.byte_valid_i && ready_r;
  assign is_print   = (b >= 8'h20) && (b != 8'h7F);
  assign last_col   = (col == COL_W'(COLS - 1));
  assign last_row   = (row == ROW_W'(ROWS - 1));
  assign do_newline = (is_print && last_col) || (b == CH_LF);
  // Next-row base is stepped by COLS rather than multiplied, and folds back to 0 on wrap.
  assign row_nl     = last_row ? '0 : row + 1'b1;
  assign base_nl    = last_row ? '0 : line_base + ADDR_W'(COLS);
  assign cur_addr   = BASE_ADDR + line_base + ADDR_W'(col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CLR_SCREEN;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      attr      <= DEF_ATTR;
      cnt       <= '0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b1;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      wr_en_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_print) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= cur_addr;
              wr_data_r <= word(attr, b);
            end
            if (do_newline) begin
              col       <= '0;
              row       <= row_nl;
              line_base <= base_nl;
              cnt       <= '0;
              state     <= S_CLR_LINE;
              ready_r   <= 1'b0;
              busy_r    <= 1'b1;
            end else if (is_print) begin
              col <= col + 1'b1;
            end else if (b == CH_CR) begin
              col <= '0;
            end else if (b == CH_BS) begin
              if (col != '0) col <= col - 1'b1;
            end else if (b == CH_FF) begin
              cnt     <= '0;
              state   <= S_CLR_SCREEN;
              ready_r <= 1'b0;
              busy_r  <= 1'b1;
`ifdef TEXT_TERM_ATTR_ESC_EN
            end else if (b == CH_ESC) begin
              state  <= S_ESC_ATTR;
              busy_r <= 1'b1;
`endif
            end
          end
        end
        S_CLR_SCREEN: begin
          // The extra terminal count cycle keeps ready low for one cycle after the last write.
          if (cnt == CNT_W'(NCELL)) begin
            state     <= S_IDLE;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
          end else begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= BASE_ADDR + ADDR_W'(cnt);
            wr_data_r <= word(attr, BLANK_CHAR);
            cnt       <= cnt + 1'b1;
          end
        end
        S_CLR_LINE: begin
          if (cnt == CNT_W'(COLS)) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            col     <= '0;
          end else begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= BASE_ADDR + line_base + ADDR_W'(cnt);
            wr_data_r <= word(attr, BLANK_CHAR);
            cnt       <= cnt + 1'b1;
          end
        end
`ifdef TEXT_TERM_ATTR_ESC_EN
        S_ESC_ATTR: begin
          // Ready stays high here so the attribute byte can be taken.
          if (bus.byte_valid_i) begin
            attr   <= b;
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = ready_r;
  assign bus.wr_en_o      = wr_en_r;
  assign bus.wr_addr_o    = wr_addr_r;
  assign bus.wr_data_o    = wr_data_r;
  assign cursor_col_o     = col;
  assign cursor_row_o     = row;
  assign busy_o           = busy_r;
endmodule

// File: tb/tb_text_term_writer.sv
// tb/tb_text_term_writer.sv - self-checking bench for text_term_writer against a screen-image model
module tb_text_term_writer;
  localparam int COLS   = 40;
  localparam int ROWS   = 20;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int NCELL  = COLS * ROWS;
  localparam int LIMIT  = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [$clog2(COLS)-1:0] cursor_col;
  logic [$clog2(ROWS)-1:0] cursor_row;
  logic busy;

  text_term_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  text_term_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE_ADDR(16'h0000), .DEF_ATTR(8'h0F), .BLANK_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cursor_col_o(cursor_col),
    .cursor_row_o(cursor_row),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] dut_mem [NCELL];
  logic [15:0] ref_mem [NCELL];
  int          ref_col, ref_row;
  logic [7:0]  ref_attr;
  bit          ref_esc;

  int          wl_addr [$];
  logic [15:0] wl_data [$];
  int          wl_cyc  [$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      if (int'(bus.wr_addr_o) < NCELL) dut_mem[bus.wr_addr_o] = bus.wr_data_o;
      wl_addr.push_back(int'(bus.wr_addr_o));
      wl_data.push_back(bus.wr_data_o);
      wl_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Screen model: a flat array of cells plus a cursor, driven by the decode rules.
  task automatic ref_reset();
    ref_attr = 8'h0F;
    ref_col = 0;
    ref_row = 0;
    ref_esc = 1'b0;
    for (int i = 0; i < NCELL; i++) ref_mem[i] = {ref_attr, 8'h20};
  endtask

  task automatic ref_newline();
    ref_col = 0;
    ref_row = (ref_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) ref_mem[ref_row * COLS + c] = {ref_attr, 8'h20};
  endtask

  task automatic ref_byte(input logic [7:0] v);
    if (ref_esc) begin
      ref_attr = v;
      ref_esc = 1'b0;
    end else if (v >= 8'h20 && v != 8'h7F) begin
      ref_mem[ref_row * COLS + ref_col] = {ref_attr, v};
      ref_col++;
      if (ref_col == COLS) ref_newline();
    end else begin
      case (v)
        8'h0D: ref_col = 0;
        8'h0A: ref_newline();
        8'h08: if (ref_col > 0) ref_col--;
        8'h0C: begin
          for (int i = 0; i < NCELL; i++) ref_mem[i] = {ref_attr, 8'h20};
          ref_col = 0;
          ref_row = 0;
        end
`ifdef TEXT_TERM_ATTR_ESC_EN
        8'h1B: ref_esc = 1'b1;
`endif
        default: ;
      endcase
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = v;
    while (bus.byte_ready_o !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check("send_ready_timeout", n, 0);
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
    ref_byte(v);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.byte_ready_o !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready_bound", (n < LIMIT), 1);
    #1;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
    wl_cyc.delete();
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < NCELL; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
    check({tag, "_col"}, 32'(cursor_col), ref_col);
    check({tag, "_row"}, 32'(cursor_row), ref_row);
  endtask

  initial begin
    int bad;
    int n;
    logic [7:0] v;
    int r;

    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    ref_reset();

    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.wr_en_o, 0);
    check("rst_wr_addr", bus.wr_addr_o, 0);
    check("rst_wr_data", bus.wr_data_o, 0);
    check("rst_ready", bus.byte_ready_o, 0);
    check("rst_busy", busy, 1);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < NCELL; i++) begin
      @(negedge clk);
      if (!(bus.wr_en_o === 1'b1 && int'(bus.wr_addr_o) == i && bus.wr_data_o === 16'h0F20 &&
            bus.byte_ready_o === 1'b0)) bad++;
    end
    check("clr_screen_seq", bad, 0);
    @(negedge clk);
    check("clr_screen_ready_801", bus.byte_ready_o, 1);
    check("clr_screen_wr_idle", bus.wr_en_o, 0);
    check("clr_screen_busy", busy, 0);
    check("clr_screen_col", cursor_col, 0);
    check("clr_screen_row", cursor_row, 0);

    send_byte(8'h41);
    check("a_wr_en", bus.wr_en_o, 1);
    check("a_wr_addr", bus.wr_addr_o, 0);
    check("a_wr_data", bus.wr_data_o, 16'h0F41);
    check("a_col", cursor_col, 1);

    send_byte(8'h0D);
    wait_ready();
    check("cr_col", cursor_col, 0);

    clear_log();
    for (int i = 0; i < COLS; i++) send_byte(8'h42);
    n = 0;
    @(negedge clk);
    while (bus.byte_ready_o !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    #1;
    check("line_wrap_ready_low", n, COLS + 1);
    check("line_wrap_nwrites", wl_addr.size(), 2 * COLS);
    bad = 0;
    for (int i = 0; i < wl_addr.size(); i++) begin
      if (wl_addr[i] != i) bad++;
      if (wl_data[i] !== ((i < COLS) ? 16'h0F42 : 16'h0F20)) bad++;
      if (wl_cyc[i] != wl_cyc[0] + i) bad++;
    end
    check("line_wrap_writes", bad, 0);
    check("line_wrap_row", cursor_row, 1);
    check("line_wrap_col", cursor_col, 0);

    for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A);
    wait_ready();
    check("lf_row19", cursor_row, ROWS - 1);
    clear_log();
    send_byte(8'h0A);
    wait_ready();
    check("row_wrap_nwrites", wl_addr.size(), COLS);
    bad = 0;
    for (int i = 0; i < wl_addr.size(); i++)
      if (wl_addr[i] != i || wl_data[i] !== 16'h0F20) bad++;
    check("row_wrap_writes", bad, 0);
    check("row_wrap_row", cursor_row, 0);
    check("row_wrap_col", cursor_col, 0);

    clear_log();
    send_byte(8'h58);
    send_byte(8'h08);
    send_byte(8'h59);
    wait_ready();
    check("bs_nwrites", wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      check("bs_addr0", wl_addr[0], 0);
      check("bs_data0", wl_data[0], 16'h0F58);
      check("bs_addr1", wl_addr[1], 0);
      check("bs_data1", wl_data[1], 16'h0F59);
    end
    check("bs_col", cursor_col, 1);
    send_byte(8'h0D);
    clear_log();
    send_byte(8'h08);
    wait_ready();
    check("bs_col0_nwrites", wl_addr.size(), 0);
    check("bs_col0_col", cursor_col, 0);

    clear_log();
    send_byte(8'h1B);
    send_byte(8'h4E);
    send_byte(8'h5A);
    wait_ready();
`ifdef TEXT_TERM_ATTR_ESC_EN
    check("esc_nwrites", wl_addr.size(), 1);
    if (wl_data.size() >= 1) check("esc_data", wl_data[0], 16'h4E5A);
`else
    check("esc_nwrites", wl_addr.size(), 2);
    if (wl_data.size() >= 2) begin
      check("esc_data0", wl_data[0], 16'h0F4E);
      check("esc_data1", wl_data[1], 16'h0F5A);
    end
`endif
    check_image("directed_image");

    send_byte(8'h0A);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", bus.wr_en_o, 0);
    check("midrst_ready", bus.byte_ready_o, 0);
    check("midrst_busy", busy, 1);
    reset = 1'b0;
    ref_reset();
    wait_ready();
    check_image("midrst_image");

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 199);
      if (r < 140) begin
        v = 8'($urandom_range(8'h20, 8'hFF));
        if (v == 8'h7F) v = 8'h41;
      end else if (r < 170) begin
        case ($urandom_range(0, 2))
          0: v = 8'h0D;
          1: v = 8'h0A;
          default: v = 8'h08;
        endcase
      end else if (r < 198) begin
        v = 8'($urandom_range(0, 31));
        if (v == 8'h0C) v = 8'h7F;
      end else begin
        v = 8'h0C;
      end
      send_byte(v);
    end
    wait_ready();
    check_image("random_image");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
